tivi_bus_master: RTL and testbench
==================================

# tivi_bus_master

Host-side initiator for the tivi register bus: turns simple command requests into 6502-style bus cycles (cs/rwb/rs/data) aligned to the phi2 clock that the tivi bus responder generates. Provides single register reads/writes plus a VRAM fill sequencer that loads the VRAM address, then issues N data writes. It sits between on-chip test or boot logic and the tivi bus block, in the same clk domain.

## Interface
- No parameters.
- clk  in  1  master clock, same domain as phi2 generator
- reset  in  1  reset, synchronous, active-high
- phi2  in  1  bus phase clock from responder, synchronous to clk
- cmd_valid  in  1  command request
- cmd_ready  out  1  high when idle and able to accept
- cmd_op  in  2  00 reg write, 01 reg read, 10 VRAM fill, 11 reserved
- cmd_rs  in  4  register select for ops 00/01
- cmd_data  in  8  write data (op 00), fill byte (op 10)
- cmd_addr  in  14  fill start VRAM address (op 10)
- cmd_count  in  14  fill byte count (op 10); 0 = address load only
- rsp_valid  out  1  one-clk pulse, read data available
- rsp_data  out  8  captured read data, held until next response
- busy  out  1  command accepted and not yet finished
- bus_cs  out  1  chip select to responder
- bus_rwb  out  1  1 read, 0 write
- bus_rs  out  4  register select
- bus_wdata  out  8  write data to responder
- bus_rdata  in  8  read data from responder

## Operation
- Falling edge detect: phi2_q registered each clk; fall = phi2_q & ~phi2. A bus slot spans fall to next fall (low phase then high phase).
- All bus_* outputs registered; they change only on fall clks (or reset).
- States: IDLE, WAIT, SINGLE, FILL_LO, FILL_HI, FILL_DATA.
- IDLE: cmd_ready=1. On cmd_valid, latch command, go WAIT, busy=1. Op 11: accepted, busy for one clk, no bus cycles, no response.
- WAIT: on next fall (not the acceptance clk's fall) drive first slot: op 00/01 → SINGLE with rs=cmd_rs, rwb=op[0], wdata=cmd_data; op 10 → FILL_LO with rs=1, wdata=addr[7:0], rwb=0.
- FILL_LO → FILL_HI on fall: rs=2, wdata={2'b00,addr[13:8]}.
- FILL_HI → on fall: count==0 → finish; else FILL_DATA: rs=0, wdata=fill byte, remaining=count.
- FILL_DATA: each fall decrements remaining; when it reaches 0 → finish. Fill depends on responder auto-increment being enabled (ctrl bit0); block never writes ctrl.
- SINGLE: on next fall → finish; if read, capture bus_rdata into rsp_data, pulse rsp_valid.
- Finish (on that fall clk): bus_cs=0, bus_rwb=1, state IDLE, busy=0; cmd_ready high from next clk.
- Between commands bus idle: cs=0, rwb=1, rs and wdata hold last values.
- cmd fields ignored unless cmd_valid && cmd_ready.

## Timing
- Reset values: cmd_ready 1 (after reset deasserted), busy 0, rsp_valid 0, rsp_data 0, bus_cs 0, bus_rwb 1, bus_rs 0, bus_wdata 0, phi2_q 0, state IDLE.
- Reset mid-operation: bus_cs drops on the next clk edge; command discarded, no response.
- Latency: single op occupies exactly one phi2 period after the first fall following acceptance; fill occupies 2+count periods.
- Read capture on the fall clk ending the slot: responder dout is stable from the high phase.
- rsp_valid asserted in the same clk edge as busy deassertion.
- Acceptance in the same clk as a fall: first slot starts on the following fall.
- cmd_count 14 bits, full range; decrement never wraps (exit at 0). VRAM address wrap handled by responder.
- phi2 held low or high: block waits indefinitely, outputs stable.

## Structure
- Shared package tivi_pkg: register index constants (VDATA=0, ADDR_LO=1, ADDR_HI=2, CTRL=3, CURSOR_CH=4, CURSOR_X=5, CURSOR_Y=6, CLKDIV=7), cmd_op codes, state enum.
- Single sub-module phi2_edge (phi2_q register, fall/rise pulses), reusable by other phi2-aligned logic.

## Test plan
- Reset: assert reset during a fill → next clk bus_cs=0, bus_rwb=1, busy=0, cmd_ready=1 after release.
- Reg write op 00 rs=5 data=0x27 against tivi bus responder (divisor 24) → one slot with cs=1, rwb=0; responder cursor_x=0x27; busy clears on ending fall.
- Reg read op 01 rs=7 after reset → rsp_valid one clk, rsp_data=24 (0x18).
- Fill addr=0x3FFE count=3 byte 0x41 → slots rs=1 0xFE, rs=2 0x3F, three rs=0 writes; VRAM 0x3FFE, 0x3FFF, 0x0000 = 0x41; 5 phi2 periods.
- Fill count=0 addr=0x0123 → only two slots; responder vaddr=0x0123, no data write.
- cmd_valid held high across completion with op 11 then op 00 → op 11 no bus activity, op 00 starts at the fall after its acceptance; cmd_ready low while busy.

Source files
------------

// File: rtl/tivi_pkg.sv
// tivi_pkg: shared definitions for the tivi register bus.
//   - Register index constants of the tivi bus responder.
//   - Command opcodes accepted by tivi_bus_master.
//   - Bus master FSM state encoding and the state type.
//   - Small helper for building the VRAM address high byte.
package tivi_pkg;

  // Responder register map
  localparam logic [3:0] REG_VDATA     = 4'd0;
  localparam logic [3:0] REG_ADDR_LO   = 4'd1;
  localparam logic [3:0] REG_ADDR_HI   = 4'd2;
  localparam logic [3:0] REG_CTRL      = 4'd3;
  localparam logic [3:0] REG_CURSOR_CH = 4'd4;
  localparam logic [3:0] REG_CURSOR_X  = 4'd5;
  localparam logic [3:0] REG_CURSOR_Y  = 4'd6;
  localparam logic [3:0] REG_CLKDIV    = 4'd7;

  // Command opcodes
  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_FILL  = 2'b10;
  localparam logic [1:0] OP_RSVD  = 2'b11;

  // Bus master FSM states, kept as plain constants so older code that
  // compares raw state codes keeps working.
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_WAIT      = 3'd1;
  localparam state_t ST_SINGLE    = 3'd2;
  localparam state_t ST_FILL_LO   = 3'd3;
  localparam state_t ST_FILL_HI   = 3'd4;
  localparam state_t ST_FILL_DATA = 3'd5;

  // ADDR_HI register takes the upper six address bits, zero-extended.
  function automatic logic [7:0] addr_hi_byte(input logic [13:0] addr);
    return {2'b00, addr[13:8]};
  endfunction

endpackage

// File: rtl/phi2_edge.sv
// phi2_edge: edge detector for the responder-generated phi2 clock.
// phi2 is synchronous to clk, so one register stage is enough.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   phi2       : bus phase clock (synchronous to clk)
//   fall       : high in the clk cycle where phi2 is seen going 1 -> 0
//   rise       : high in the clk cycle where phi2 is seen going 0 -> 1
module phi2_edge (
  input  logic clk,
  input  logic reset,
  input  logic phi2,
  output logic fall,
  output logic rise
);

  logic phi2_q;

  always_ff @(posedge clk) begin
    if (reset) phi2_q <= 1'b0;
    else       phi2_q <= phi2;
  end

  assign fall = phi2_q & ~phi2;
  assign rise = ~phi2_q & phi2;

endmodule

// File: rtl/tivi_bus_master.sv
// tivi_bus_master: host-side initiator for the tivi register bus.
// Turns command requests into phi2-aligned bus slots. A slot runs from
// one phi2 fall to the next; all bus outputs are registered and only
// change on fall cycles (or reset).
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   phi2              : bus phase clock from the responder
//   cmd_valid/ready   : command handshake (accepted when both high)
//   cmd_op            : 00 reg write, 01 reg read, 10 VRAM fill, 11 no-op
//   cmd_rs, cmd_data  : register select / write data or fill byte
//   cmd_addr, cmd_count : fill start address and byte count (0 = load only)
//   rsp_valid, rsp_data : one-clk read response pulse, data held after
//   busy              : command in progress
//   bus_cs, bus_rwb, bus_rs, bus_wdata, bus_rdata : responder bus
module tivi_bus_master
  import tivi_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        phi2,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [3:0]  cmd_rs,
  input  logic [7:0]  cmd_data,
  input  logic [13:0] cmd_addr,
  input  logic [13:0] cmd_count,
  output logic        rsp_valid,
  output logic [7:0]  rsp_data,
  output logic        busy,
  output logic        bus_cs,
  output logic        bus_rwb,
  output logic [3:0]  bus_rs,
  output logic [7:0]  bus_wdata,
  input  logic [7:0]  bus_rdata
);

  logic fall;

  phi2_edge u_phi2_edge (
    .clk   (clk),
    .reset (reset),
    .phi2  (phi2),
    .fall  (fall),
    .rise  ()
  );

  state_t      state_reg;
  logic [1:0]  op_reg;
  logic [3:0]  rs_reg;
  logic [7:0]  data_reg;
  logic [13:0] addr_reg;
  logic [13:0] count_reg;
  logic [13:0] remaining_reg;
  logic        rsp_valid_reg;
  logic [7:0]  rsp_data_reg;
  logic        bus_cs_reg;
  logic        bus_rwb_reg;
  logic [3:0]  bus_rs_reg;
  logic [7:0]  bus_wdata_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      op_reg        <= OP_WRITE;
      rs_reg        <= 4'd0;
      data_reg      <= 8'd0;
      addr_reg      <= 14'd0;
      count_reg     <= 14'd0;
      remaining_reg <= 14'd0;
      rsp_valid_reg <= 1'b0;
      rsp_data_reg  <= 8'd0;
      bus_cs_reg    <= 1'b0;
      bus_rwb_reg   <= 1'b1;
      bus_rs_reg    <= 4'd0;
      bus_wdata_reg <= 8'd0;
    end else begin
      rsp_valid_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (cmd_valid) begin
            op_reg    <= cmd_op;
            rs_reg    <= cmd_rs;
            data_reg  <= cmd_data;
            addr_reg  <= cmd_addr;
            count_reg <= cmd_count;
            state_reg <= ST_WAIT;
          end
        end

        // Any fall seen here is strictly after the acceptance cycle,
        // because phi2_q was refreshed on the acceptance edge.
        ST_WAIT: begin
          if (op_reg == OP_RSVD) begin
            state_reg <= ST_IDLE;
          end else if (fall) begin
            bus_cs_reg <= 1'b1;
            if (op_reg == OP_FILL) begin
              bus_rs_reg    <= REG_ADDR_LO;
              bus_rwb_reg   <= 1'b0;
              bus_wdata_reg <= addr_reg[7:0];
              state_reg     <= ST_FILL_LO;
            end else begin
              bus_rs_reg    <= rs_reg;
              bus_rwb_reg   <= op_reg[0];
              bus_wdata_reg <= data_reg;
              state_reg     <= ST_SINGLE;
            end
          end
        end

        // Responder read data is stable from the high phase, so it is
        // captured on the fall that closes the slot.
        ST_SINGLE: begin
          if (fall) begin
            if (bus_rwb_reg) begin
              rsp_data_reg  <= bus_rdata;
              rsp_valid_reg <= 1'b1;
            end
            bus_cs_reg  <= 1'b0;
            bus_rwb_reg <= 1'b1;
            state_reg   <= ST_IDLE;
          end
        end

        ST_FILL_LO: begin
          if (fall) begin
            bus_rs_reg    <= REG_ADDR_HI;
            bus_wdata_reg <= addr_hi_byte(addr_reg);
            state_reg     <= ST_FILL_HI;
          end
        end

        ST_FILL_HI: begin
          if (fall) begin
            if (count_reg == 14'd0) begin
              bus_cs_reg  <= 1'b0;
              bus_rwb_reg <= 1'b1;
              state_reg   <= ST_IDLE;
            end else begin
              bus_rs_reg    <= REG_VDATA;
              bus_wdata_reg <= data_reg;
              remaining_reg <= count_reg;
              state_reg     <= ST_FILL_DATA;
            end
          end
        end

        // Each fall closes one VDATA write; the responder's address
        // auto-increment advances VRAM between slots. remaining is never
        // zero here, so the decrement cannot wrap.
        ST_FILL_DATA: begin
          if (fall) begin
            remaining_reg <= remaining_reg - 14'd1;
            if (remaining_reg == 14'd1) begin
              bus_cs_reg  <= 1'b0;
              bus_rwb_reg <= 1'b1;
              state_reg   <= ST_IDLE;
            end
          end
        end

        default: begin
          bus_cs_reg  <= 1'b0;
          bus_rwb_reg <= 1'b1;
          state_reg   <= ST_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready = (state_reg == ST_IDLE);
  assign busy      = (state_reg != ST_IDLE);
  assign rsp_valid = rsp_valid_reg;
  assign rsp_data  = rsp_data_reg;
  assign bus_cs    = bus_cs_reg;
  assign bus_rwb   = bus_rwb_reg;
  assign bus_rs    = bus_rs_reg;
  assign bus_wdata = bus_wdata_reg;

endmodule

// File: tb/tb_tivi_bus_master.sv
// tb_tivi_bus_master: table-driven bench for tivi_bus_master with a small
// behavioural tivi responder (phi2 generator, register file, VRAM with
// address auto-increment) and hand-written multi-cycle sequences.
module tb_tivi_bus_master;
  import tivi_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        phi2;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [3:0]  cmd_rs;
  logic [7:0]  cmd_data;
  logic [13:0] cmd_addr;
  logic [13:0] cmd_count;
  logic        rsp_valid;
  logic [7:0]  rsp_data;
  logic        busy;
  logic        bus_cs;
  logic        bus_rwb;
  logic [3:0]  bus_rs;
  logic [7:0]  bus_wdata;
  logic [7:0]  bus_rdata;

  always #5 clk = ~clk;

  tivi_bus_master dut (
    .clk       (clk),
    .reset     (reset),
    .phi2      (phi2),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_rs    (cmd_rs),
    .cmd_data  (cmd_data),
    .cmd_addr  (cmd_addr),
    .cmd_count (cmd_count),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .busy      (busy),
    .bus_cs    (bus_cs),
    .bus_rwb   (bus_rwb),
    .bus_rs    (bus_rs),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata)
  );

  // ---------------- responder model ----------------
  logic [2:0]  div = 3'd0;
  logic        phi2_run = 1'b1;
  logic        phi2_d = 1'b0;
  logic        tb_fall;
  logic [7:0]  regs [8];
  logic [7:0]  vram [16384];
  logic [13:0] vaddr = 14'd0;
  int          fall_cnt = 0;
  int          slot_cnt = 0;
  int          acc_cnt = 0;
  int          acc_fall = 0;
  int          vram_writes = 0;
  logic [3:0]  log_rs  [256];
  logic        log_rwb [256];
  logic [7:0]  log_wd  [256];

  assign phi2    = div[2];           // 4 clks low, 4 clks high
  assign tb_fall = phi2_d & ~phi2;

  always_comb begin
    bus_rdata = 8'h00;
    case (bus_rs)
      4'd0:    bus_rdata = vram[vaddr];
      4'd1:    bus_rdata = vaddr[7:0];
      4'd2:    bus_rdata = {2'b00, vaddr[13:8]};
      default: if (bus_rs < 4'd8) bus_rdata = regs[bus_rs[2:0]];
    endcase
  end

  always @(posedge clk) begin
    if (phi2_run) div <= div + 3'd1;
    phi2_d   <= phi2;
    fall_cnt <= fall_cnt + int'(tb_fall);
    if (cmd_valid && cmd_ready && !reset) begin
      acc_cnt  <= acc_cnt + 1;
      acc_fall <= fall_cnt + int'(tb_fall);
    end
    if (tb_fall && bus_cs && !reset) begin
      log_rs[slot_cnt[7:0]]  <= bus_rs;
      log_rwb[slot_cnt[7:0]] <= bus_rwb;
      log_wd[slot_cnt[7:0]]  <= bus_wdata;
      slot_cnt <= slot_cnt + 1;
      if (!bus_rwb) begin
        case (bus_rs)
          4'd0: begin
            vram[vaddr] <= bus_wdata;
            vaddr       <= vaddr + 14'd1;   // auto-increment assumed enabled
            vram_writes <= vram_writes + 1;
          end
          4'd1:    vaddr[7:0]  <= bus_wdata;
          4'd2:    vaddr[13:8] <= bus_wdata[5:0];
          default: if (bus_rs < 4'd8) regs[bus_rs[2:0]] <= bus_wdata;
        endcase
      end
    end
  end

  // Bus outputs may only move on a fall edge or under reset.
  logic        chg_ok = 1'b1;
  logic        armed = 1'b0;
  logic [13:0] bus_prev = '0;
  int          stable_bad = 0;
  always @(posedge clk) chg_ok <= tb_fall | reset;
  always @(negedge clk) begin
    if (armed && !chg_ok && {bus_cs, bus_rwb, bus_rs, bus_wdata} !== bus_prev)
      stable_bad <= stable_bad + 1;
    bus_prev <= {bus_cs, bus_rwb, bus_rs, bus_wdata};
  end

  // ---------------- checking ----------------
  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  typedef struct {
    string      name;
    logic [1:0] op;
    logic [3:0] rs;
    logic [7:0] data;
    logic [13:0] addr;
    logic [13:0] count;
    int         exp_slots;
    int         exp_rsp;
    logic [7:0] exp_rdata;
    logic [3:0] exp_rs0;
    logic       exp_rwb0;
    logic [7:0] exp_wd0;
  } vec_t;

  vec_t vecs [9];

  // Issue one command and follow it to completion.
  task automatic run_cmd(input vec_t v, input bit align);
    int guard, s0, a0, first_falls, pulses;
    bit seen;
    logic [7:0] pre_rdata, got_rdata;
    guard = 0;
    @(negedge clk);
    while (!cmd_ready && guard < 5000) begin @(negedge clk); guard++; end
    if (align) while (!(phi2_d && !phi2) && guard < 5000) begin @(negedge clk); guard++; end
    s0 = slot_cnt; a0 = acc_cnt; pre_rdata = rsp_data;
    cmd_valid = 1'b1; cmd_op = v.op; cmd_rs = v.rs; cmd_data = v.data;
    cmd_addr = v.addr; cmd_count = v.count;
    @(negedge clk);
    cmd_valid = 1'b0;
    check({v.name, "_accept"}, acc_cnt - a0, 1);
    seen = 1'b0; pulses = 0; first_falls = -1; got_rdata = rsp_data;
    while (guard < 5000) begin
      if (bus_cs && !seen) begin seen = 1'b1; first_falls = fall_cnt - acc_fall; end
      if (rsp_valid) begin pulses++; got_rdata = rsp_data; end
      if (!busy) break;
      @(negedge clk); guard++;
    end
    check({v.name, "_timeout"}, (guard < 5000) ? 1 : 0, 1);
    check({v.name, "_slots"}, slot_cnt - s0, v.exp_slots);
    if (v.exp_slots > 0) begin
      check({v.name, "_first_slot_fall"}, first_falls, 1);
      check({v.name, "_rs0"},  log_rs[s0[7:0]],  v.exp_rs0);
      check({v.name, "_rwb0"}, log_rwb[s0[7:0]], v.exp_rwb0);
      check({v.name, "_wd0"},  log_wd[s0[7:0]],  v.exp_wd0);
    end
    check({v.name, "_rsp_pulses"}, pulses, v.exp_rsp);
    if (v.exp_rsp > 0) check({v.name, "_rsp_data"}, got_rdata, v.exp_rdata);
    else               check({v.name, "_rsp_held"}, rsp_data, pre_rdata);
    check({v.name, "_idle_bus"}, {bus_cs, bus_rwb, cmd_ready}, 3'b011);
    @(negedge clk);
    check({v.name, "_rsp_one_clk"}, rsp_valid, 1'b0);
    $display("[TB] txn %s op=%0d rs=%0d data=0x%02h addr=0x%04h count=%0d slots=%0d rsp=%0d rdata=0x%02h",
             v.name, v.op, v.rs, v.data, v.addr, v.count, slot_cnt - s0, pulses, got_rdata);
  endtask

  initial begin
    int s0, a0, guard, ff;
    vec_t v;
    for (int i = 0; i < 16384; i++) vram[i] = 8'h00;
    for (int i = 0; i < 8; i++) regs[i] = 8'h00;
    regs[7] = 8'd24;

    //           name          op     rs    data   addr      count  sl rsp rdata rs0 rwb0 wd0
    vecs[0] = '{"rd_clkdiv",   2'b01, 4'd7, 8'h00, 14'h0000, 14'd0, 1, 1, 8'h18, 4'd7, 1'b1, 8'h00};
    vecs[1] = '{"wr_cursor_x", 2'b00, 4'd5, 8'h27, 14'h0000, 14'd0, 1, 0, 8'h00, 4'd5, 1'b0, 8'h27};
    vecs[2] = '{"rd_cursor_x", 2'b01, 4'd5, 8'h00, 14'h0000, 14'd0, 1, 1, 8'h27, 4'd5, 1'b1, 8'h00};
    vecs[3] = '{"wr_cursor_ch",2'b00, 4'd4, 8'hC3, 14'h0000, 14'd0, 1, 0, 8'h00, 4'd4, 1'b0, 8'hC3};
    vecs[4] = '{"rd_cursor_ch",2'b01, 4'd4, 8'h00, 14'h0000, 14'd0, 1, 1, 8'hC3, 4'd4, 1'b1, 8'h00};
    vecs[5] = '{"fill_cnt0",   2'b10, 4'd9, 8'h55, 14'h0123, 14'd0, 2, 0, 8'h00, 4'd1, 1'b0, 8'h23};
    vecs[6] = '{"op_rsvd",     2'b11, 4'd2, 8'hFF, 14'h3FFF, 14'd7, 0, 0, 8'h00, 4'd0, 1'b1, 8'h00};
    vecs[7] = '{"rd_addr_lo",  2'b01, 4'd1, 8'h00, 14'h0000, 14'd0, 1, 1, 8'h23, 4'd1, 1'b1, 8'h00};
    vecs[8] = '{"rd_addr_hi",  2'b01, 4'd2, 8'h00, 14'h0000, 14'd0, 1, 1, 8'h01, 4'd2, 1'b1, 8'h00};

    reset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_rs = 4'd0;
    cmd_data = 8'h00; cmd_addr = 14'd0; cmd_count = 14'd0;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    armed = 1'b1;

    // Reset values
    check("rst_cmd_ready", cmd_ready, 1'b1);
    check("rst_busy",      busy,      1'b0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_data",  rsp_data,  8'h00);
    check("rst_bus",       {bus_cs, bus_rwb, bus_rs, bus_wdata}, {1'b0, 1'b1, 4'd0, 8'h00});

    // Table-driven single ops and short fill
    for (int i = 0; i < 9; i++) begin
      run_cmd(vecs[i], 1'b0);
      if (i == 1) check("resp_cursor_x", regs[5], 8'h27);
      if (i == 5) begin
        check("fill0_vaddr", vaddr, 14'h0123);
        check("fill0_no_vram_write", vram_writes, 0);
      end
    end

    // Fill across the VRAM wrap
    s0 = slot_cnt;
    v = '{"fill_wrap", 2'b10, 4'd0, 8'h41, 14'h3FFE, 14'd3, 5, 0, 8'h00, 4'd1, 1'b0, 8'hFE};
    run_cmd(v, 1'b0);
    check("fw_slot1", {log_rs[s0+1], log_rwb[s0+1], log_wd[s0+1]}, {4'd2, 1'b0, 8'h3F});
    for (int k = 2; k < 5; k++)
      check("fw_data_slot", {log_rs[s0+k], log_rwb[s0+k], log_wd[s0+k]}, {4'd0, 1'b0, 8'h41});
    check("fw_vram_3ffe", vram[14'h3FFE], 8'h41);
    check("fw_vram_3fff", vram[14'h3FFF], 8'h41);
    check("fw_vram_0000", vram[14'h0000], 8'h41);
    check("fw_vaddr",     vaddr,          14'h0001);

    // Acceptance on the same clk as a fall
    v = '{"wr_on_fall", 2'b00, 4'd6, 8'h5A, 14'h0000, 14'd0, 1, 0, 8'h00, 4'd6, 1'b0, 8'h5A};
    run_cmd(v, 1'b1);

    // Reserved op then write with cmd_valid held high throughout
    @(negedge clk);
    s0 = slot_cnt; a0 = acc_cnt;
    cmd_valid = 1'b1; cmd_op = 2'b11; cmd_rs = 4'd2; cmd_data = 8'h99;
    @(negedge clk);
    check("held_ready_low", cmd_ready, 1'b0);
    check("held_busy",      busy,      1'b1);
    cmd_op = 2'b00; cmd_rs = 4'd6; cmd_data = 8'h12;
    @(negedge clk);
    check("held_op11_done", {busy, cmd_ready}, 2'b01);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("held_two_accepts", acc_cnt - a0, 2);
    check("held_ready_busy",  {busy, cmd_ready}, 2'b10);
    guard = 0;
    while (!bus_cs && guard < 200) begin @(negedge clk); guard++; end
    ff = fall_cnt - acc_fall;
    check("held_cs_seen",    bus_cs, 1'b1);
    check("held_no_op11_slot", slot_cnt - s0, 0);
    check("held_first_fall", ff, 1);
    while (busy && guard < 200) begin @(negedge clk); guard++; end
    check("held_done",  busy, 1'b0);
    check("held_slots", slot_cnt - s0, 1);
    check("held_slot",  {log_rs[s0], log_rwb[s0], log_wd[s0]}, {4'd6, 1'b0, 8'h12});
    check("held_reg6",  regs[6], 8'h12);
    $display("[TB] txn held_valid op11+op00 accepts=%0d slots=%0d", acc_cnt - a0, slot_cnt - s0);

    // phi2 stopped: command waits with bus idle, resumes when phi2 restarts
    @(negedge clk);
    phi2_run = 1'b0;
    s0 = slot_cnt;
    cmd_valid = 1'b1; cmd_op = 2'b00; cmd_rs = 4'd5; cmd_data = 8'h33;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (40) @(negedge clk);
    check("stall_busy", {busy, bus_cs}, 2'b10);
    phi2_run = 1'b1;
    guard = 0;
    while (busy && guard < 200) begin @(negedge clk); guard++; end
    check("stall_done", {busy, slot_cnt - s0}, {1'b0, 32'd1});
    check("stall_reg5", regs[5], 8'h33);
    $display("[TB] txn phi2_stall wr rs=5 data=0x33 slots=%0d", slot_cnt - s0);

    // Reset in the middle of a long fill
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'b10; cmd_addr = 14'h0100; cmd_count = 14'd20; cmd_data = 8'h77;
    @(negedge clk);
    cmd_valid = 1'b0;
    guard = 0;
    while (slot_cnt - s0 < 4 && guard < 500) begin @(negedge clk); guard++; end
    check("rstmid_cs_active", bus_cs, 1'b1);
    reset = 1'b1;
    @(posedge clk); #1;
    check("rstmid_bus", {bus_cs, bus_rwb, busy}, 3'b010);
    @(negedge clk);
    reset = 1'b0;
    check("rstmid_ready", cmd_ready, 1'b1);
    s0 = slot_cnt;
    repeat (40) begin
      @(negedge clk);
      if (rsp_valid || bus_cs) guard = 9999;
    end
    check("rstmid_quiet", {slot_cnt - s0, guard == 9999}, {32'd0, 1'b0});
    $display("[TB] txn reset_mid_fill cs=%0d busy=%0d", bus_cs, busy);

    check("bus_stable_between_falls", stable_bad, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
